// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive front end.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_e;

  localparam logic [3:0] OS_MID  = 4'd7;
  localparam logic [3:0] OS_LAST = 4'd15;

  localparam logic [7:0] PRINT_MIN  = 8'h20;
  localparam logic [7:0] PRINT_MAX  = 8'h7E;
  localparam logic [7:0] RESET_CHAR = 8'h20;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_MIN) && (b <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/uart_rx_frontend_os_tick.sv
// Oversample tick generator: one-cycle tick every OVS_DIV clocks, restartable via clr.
module uart_os_tick #(
  parameter int OVS_DIV = 651
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            CW       = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CNT_LAST);
  assign tick   = w_wrap && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// 16x-oversampled 8N1 UART receiver with held last-printable register.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BAUD    = 9600,
  parameter int OVS_DIV = CLK_HZ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RsRx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic [7:0] last_valid,
  output logic       busy
);

  logic       r_rx_meta, r_rx_s;
  state_e     r_state, w_state;
  logic [3:0] r_os_cnt, w_os_cnt;
  logic [2:0] r_bit_idx, w_bit_idx;
  logic [7:0] r_shift, w_shift;
  logic [7:0] r_data, w_data;
  logic [7:0] r_last, w_last;
  logic       r_valid, w_valid;
  logic       r_ferr, w_ferr;
  logic       w_tick, w_clr, w_par_ok;

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking so r_rx_s takes the old r_rx_meta, giving two real flops.
      r_rx_meta <= RsRx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Holding the divider clear in IDLE phase-aligns ticks to the start edge.
  assign w_clr = (r_state == IDLE);

  uart_os_tick #(.OVS_DIV(OVS_DIV)) u_os_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .tick  (w_tick)
  );

`ifdef UART_RX_PARITY_EN
  logic r_par_bit, w_par_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_par_bit <= 1'b0;
    else        r_par_bit <= w_par_bit;
  end

  assign w_par_ok = ~(^{r_shift, r_par_bit});
`else
  assign w_par_ok = 1'b1;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state   = r_state;
    w_os_cnt  = r_os_cnt;
    w_bit_idx = r_bit_idx;
    w_shift   = r_shift;
    w_data    = r_data;
    w_last    = r_last;
    w_valid   = 1'b0;
    w_ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bit = r_par_bit;
`endif
    unique case (r_state)
      IDLE: begin
        w_os_cnt  = 4'd0;
        w_bit_idx = 3'd0;
        if (!r_rx_s) w_state = START;
      end
      START: if (w_tick) begin
        if (r_os_cnt == OS_MID) begin
          w_os_cnt = 4'd0;
          w_state  = r_rx_s ? IDLE : DATA;
        end else begin
          w_os_cnt = r_os_cnt + 4'd1;
        end
      end
      DATA: if (w_tick) begin
        w_os_cnt = r_os_cnt + 4'd1;
        if (r_os_cnt == OS_LAST) begin
          w_shift   = {r_rx_s, r_shift[7:1]};
          w_bit_idx = r_bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (r_bit_idx == 3'd7) w_state = PARITY;
`else
          if (r_bit_idx == 3'd7) w_state = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (w_tick) begin
        w_os_cnt = r_os_cnt + 4'd1;
        if (r_os_cnt == OS_LAST) begin
          w_par_bit = r_rx_s;
          w_state   = STOP;
        end
      end
`endif
      STOP: if (w_tick) begin
        w_os_cnt = r_os_cnt + 4'd1;
        if (r_os_cnt == OS_LAST) begin
          if (!r_rx_s) begin
            w_ferr  = 1'b1;
            w_state = BREAK;
          end else begin
            w_state = IDLE;
            if (w_par_ok) begin
              w_data  = r_shift;
              w_valid = 1'b1;
              if (is_printable(r_shift)) w_last = r_shift;
            end else begin
              w_ferr = 1'b1;
            end
          end
        end
      end
      BREAK: if (r_rx_s) w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_os_cnt  <= 4'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_last    <= RESET_CHAR;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_os_cnt  <= w_os_cnt;
      r_bit_idx <= w_bit_idx;
      r_shift   <= w_shift;
      r_data    <= w_data;
      r_last    <= w_last;
      r_valid   <= w_valid;
      r_ferr    <= w_ferr;
    end
  end

  assign data       = r_data;
  assign last_valid = r_last;
  assign valid      = r_valid;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: frame-level expectation queue plus literal spot checks.
module tb_uart_rx_frontend;

  localparam int CLK_HZ   = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT_CLKS = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int NOM_LAT  = BIT_CLKS * 21 / 2;
`else
  localparam int NOM_LAT  = BIT_CLKS * 19 / 2;
`endif
  localparam int TOL      = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RsRx = 1'b1;
  logic [7:0] data, last_valid;
  logic       valid, frame_err, busy;

  uart_rx_frontend #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RsRx       (RsRx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .last_valid (last_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] b;
    int         t0;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_last = 8'h20;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: each completed frame yields exactly one pulse, in order, near mid-stop-bit.
  always @(negedge clk) begin : cmp
    ev_t ev;
    int  lat;
    if (!rst_n) begin
      exp_q.delete();
      m_data = 8'h00;
      m_last = 8'h20;
      check("rst_data", 32'(data), 32'h00);
      check("rst_last_valid", 32'(last_valid), 32'h20);
      check("rst_pulses", 32'({valid, frame_err}), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
    end else begin
      check("valid_ferr_exclusive", 32'(valid && frame_err), 32'h0);
      if (valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'({valid, frame_err}), 32'h0);
        end else begin
          ev  = exp_q.pop_front();
          lat = cyc - ev.t0;
          check($sformatf("pulse_kind_b%0h", ev.b), 32'(frame_err), 32'(ev.is_err));
          check($sformatf("pulse_latency_%0d", lat),
                32'(lat >= NOM_LAT - TOL && lat <= NOM_LAT + TOL), 32'h1);
          if (!ev.is_err) begin
            m_data = ev.b;
            if (ev.b >= 8'h20 && ev.b <= 8'h7E) m_last = ev.b;
          end
        end
      end
      check("data", 32'(data), 32'(m_data));
      check("last_valid", 32'(last_valid), 32'(m_last));
    end
  end

  task automatic drive(input logic v, input int n);
    RsRx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip,
                            input int extra_low, input int idle_after);
    ev_t  e;
    logic par;
    par      = (^b) ^ par_flip;
    e.b      = b;
    e.t0     = cyc;
`ifdef UART_RX_PARITY_EN
    e.is_err = !stop || par_flip;
`else
    e.is_err = !stop;
`endif
    exp_q.push_back(e);
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive(b[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    drive(par, BIT_CLKS);
`else
    if (par_flip) par = ~par;
`endif
    drive(stop, BIT_CLKS);
    if (extra_low > 0) drive(1'b0, extra_low);
    if (idle_after > 0) drive(1'b1, idle_after);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_queue", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin : stim
    logic [7:0] b7a;
    b7a = 8'h7A;
    repeat (5) @(posedge clk);
    #1;
    check("init_data", 32'(data), 32'h00);
    check("init_last_valid", 32'(last_valid), 32'h20);
    rst_n = 1'b1;
    drive(1'b1, 20);

    send_frame(8'h41, 1'b1, 1'b0, 0, BIT_CLKS);
    wait_drain();
    check("A_data", 32'(data), 32'h41);
    check("A_last_valid", 32'(last_valid), 32'h41);
    check("A_busy_idle", 32'(busy), 32'h0);

    send_frame(8'h0D, 1'b1, 1'b0, 0, BIT_CLKS);
    wait_drain();
    check("CR_data", 32'(data), 32'h0D);
    check("CR_last_valid", 32'(last_valid), 32'h41);

    // Back-to-back frames on the printable boundaries.
    send_frame(8'h20, 1'b1, 1'b0, 0, 0);
    send_frame(8'h7F, 1'b1, 1'b0, 0, BIT_CLKS);
    wait_drain();
    check("b2b_data", 32'(data), 32'h7F);
    check("b2b_last_valid", 32'(last_valid), 32'h20);

    drive(1'b0, 40);
    drive(1'b1, 3 * BIT_CLKS);
    check("glitch_busy", 32'(busy), 32'h0);
    check("glitch_data", 32'(data), 32'h7F);

    send_frame(8'h55, 1'b0, 1'b0, 3 * BIT_CLKS, BIT_CLKS);
    wait_drain();
    check("break_data_held", 32'(data), 32'h7F);
    send_frame(8'h42, 1'b1, 1'b0, 0, BIT_CLKS);
    wait_drain();
    check("after_break_data", 32'(data), 32'h42);
    check("after_break_last", 32'(last_valid), 32'h42);

    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive(b7a[i], BIT_CLKS);
    drive(b7a[4], BIT_CLKS / 2);
    check("midframe_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    RsRx  = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("inreset_data", 32'(data), 32'h00);
    check("inreset_last_valid", 32'(last_valid), 32'h20);
    check("inreset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    drive(1'b1, BIT_CLKS);
    send_frame(8'h30, 1'b1, 1'b0, 0, BIT_CLKS);
    wait_drain();
    check("post_reset_data", 32'(data), 32'h30);
    check("post_reset_last", 32'(last_valid), 32'h30);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h41, 1'b1, 1'b0, 0, BIT_CLKS);
    wait_drain();
    check("par_ok_data", 32'(data), 32'h41);
    send_frame(8'h43, 1'b1, 1'b1, 0, BIT_CLKS);
    wait_drain();
    check("par_bad_data_held", 32'(data), 32'h41);
    check("par_bad_last_held", 32'(last_valid), 32'h41);
`endif

    drive(1'b1, BIT_CLKS);
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
